prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: SYNC, word count, big-endian payload words written to program memory.
// Optional trailing checksum byte and error path enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int          PC_WIDTH          = 8,
   parameter int          PROGRAM_DataWidth = 16,
   parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   byte_in,
   input  logic                         byte_valid,
   output logic                         byte_ready,
   input  logic                         clear,
   output logic                         prog_wr_en,
   output logic [PC_WIDTH-1:0]          prog_addr,
   output logic [PROGRAM_DataWidth-1:0] prog_data,
   output logic                         cpu_hold,
   output logic                         done,
   output logic                         error
);

   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, DONE, ERR} state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t LAST_STATE = CSUM;
`else
   localparam state_t LAST_STATE = DONE;
`endif

   state_t                         state_reg, state_next;
   logic [7:0]                     n_reg;
   logic [7:0]                     idx_reg;
   logic [7:0]                     hi_reg;
   logic                           prog_wr_en_reg;
   logic [PC_WIDTH-1:0]            prog_addr_reg;
   logic [PROGRAM_DataWidth-1:0]   prog_data_reg;
   logic                           take;
   logic                           last_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]                     sum_reg;
`endif

   assign byte_ready = (state_reg != DONE) && (state_reg != ERR);
   assign take       = byte_valid && byte_ready;
   assign last_word  = (idx_reg == 8'(n_reg - 8'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (take && byte_in == SYNC_BYTE) state_next = COUNT;
         COUNT: if (take) state_next = (byte_in == 8'd0) ? LAST_STATE : HI;
         HI:    if (take) state_next = LO;
         LO:    if (take) state_next = last_word ? LAST_STATE : HI;
`ifdef LOADER_CHECKSUM_EN
         CSUM:  if (take) state_next = (8'(sum_reg + byte_in) == 8'd0) ? DONE : ERR;
`endif
         default: state_next = state_reg;
      endcase
      // clear wins over any byte accepted in the same cycle
      if (clear) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_reg          <= '0;
         idx_reg        <= '0;
         hi_reg         <= '0;
         prog_wr_en_reg <= 1'b0;
         prog_addr_reg  <= '0;
         prog_data_reg  <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_reg        <= '0;
`endif
      end else begin
         prog_wr_en_reg <= 1'b0;
         if (!clear && take) begin
            case (state_reg)
               COUNT: begin
                  n_reg   <= byte_in;
                  idx_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_reg <= byte_in;
`endif
               end
               HI: begin
                  hi_reg  <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                  sum_reg <= 8'(sum_reg + byte_in);
`endif
               end
               LO: begin
                  prog_wr_en_reg <= 1'b1;
                  prog_addr_reg  <= PC_WIDTH'(idx_reg);
                  prog_data_reg  <= {hi_reg, byte_in};
                  idx_reg        <= 8'(idx_reg + 8'd1);
`ifdef LOADER_CHECKSUM_EN
                  sum_reg        <= 8'(sum_reg + byte_in);
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign prog_wr_en = prog_wr_en_reg;
   assign prog_addr  = prog_addr_reg;
   assign prog_data  = prog_data_reg;

   // done is withheld while the final word's strobe is still on the bus
   assign done     = (state_reg == DONE) && !prog_wr_en_reg;
   assign cpu_hold = (state_reg != IDLE) && !done;
`ifdef LOADER_CHECKSUM_EN
   assign error    = (state_reg == ERR);
`else
   assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboard of expected program writes checked on each strobe.
// Follows LOADER_CHECKSUM_EN the same way as the design (checksum byte appended when defined).
module tb_prog_loader;

   localparam logic [7:0] SYNC = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        clear = 1'b0;
   logic        prog_wr_en;
   logic [7:0]  prog_addr;
   logic [15:0] prog_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   logic [23:0] sb[$];
   logic [15:0] words[$];

`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   prog_loader #(.PC_WIDTH(8), .PROGRAM_DataWidth(16), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .clear(clear), .prog_wr_en(prog_wr_en),
      .prog_addr(prog_addr), .prog_data(prog_data), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // every strobe must match the oldest outstanding expected write
   always @(negedge clk) begin
      if (rst_n && prog_wr_en) begin
         logic [23:0] exp_w;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL unexpected_write observed=%0h expected=none", {prog_addr, prog_data});
         end else begin
            exp_w = sb.pop_front();
            assert ({prog_addr, prog_data} === exp_w) else begin
               errors++;
               $error("FAIL write observed=%0h expected=%0h", {prog_addr, prog_data}, exp_w);
            end
            $display("write addr=%0h data=%0h", prog_addr, prog_data);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   // sends SYNC, count, the queued words and (when enabled) a good or corrupted checksum
   task automatic send_frame(input bit good);
      logic [7:0] sum;
      int n;
      n = words.size();
      send(SYNC);
      send(8'(n));
      sum = 8'(n);
      for (int i = 0; i < n; i++) begin
         sb.push_back({8'(i), words[i]});
         send(words[i][15:8]);
         send(words[i][7:0]);
         sum = 8'(sum + words[i][15:8] + words[i][7:0]);
      end
      if (CSUM_ON) send(good ? 8'(8'd0 - sum) : 8'(8'd1 - sum));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_wr_en", 32'(prog_wr_en), 32'd0);
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // frame 1: two words, good checksum
      words = '{16'h0801, 16'h4800};
      send_frame(1'b1);
      chk("f1_done_first", 32'(done), CSUM_ON ? 32'd1 : 32'd0);
      cyc(1);
      chk("f1_done", 32'(done), 32'd1);
      chk("f1_hold", 32'(cpu_hold), 32'd0);
      chk("f1_error", 32'(error), 32'd0);
      chk("f1_ready", 32'(byte_ready), 32'd0);
      chk("f1_hold_addr", 32'(prog_addr), 32'd1);
      chk("f1_hold_data", 32'(prog_data), 32'h4800);
      chk("f1_drain", 32'(sb.size()), 32'd0);
      $display("frame1 done=%0b error=%0b", done, error);
      do_clear();
      chk("clr_done", 32'(done), 32'd0);
      chk("clr_ready", 32'(byte_ready), 32'd1);

      // frame 2: bad checksum
      if (CSUM_ON) begin
         words = '{16'h0801, 16'h4800};
         send_frame(1'b0);
         cyc(1);
         chk("f2_error", 32'(error), 32'd1);
         chk("f2_done", 32'(done), 32'd0);
         chk("f2_hold", 32'(cpu_hold), 32'd1);
         chk("f2_ready", 32'(byte_ready), 32'd0);
         $display("frame2 done=%0b error=%0b", done, error);
         do_clear();
         chk("f2_clr_error", 32'(error), 32'd0);
         chk("f2_clr_hold", 32'(cpu_hold), 32'd0);
      end

      // junk before sync, then an empty frame
      send(8'h00);
      send(8'h5A);
      chk("junk_hold", 32'(cpu_hold), 32'd0);
      words = {};
      send_frame(1'b1);
      chk("empty_done", 32'(done), 32'd1);
      $display("empty frame done=%0b", done);
      do_clear();

      // abort mid-frame; clear overrides a byte offered in the same cycle
      send(SYNC);
      send(8'h03);
      send(8'h10);
      byte_in = 8'h3F;
      byte_valid = 1'b1;
      do_clear();
      byte_valid = 1'b0;
      chk("abort_hold", 32'(cpu_hold), 32'd0);
      chk("abort_ready", 32'(byte_ready), 32'd1);
      cyc(2);
      words = '{16'h803F};
      send_frame(1'b1);
      cyc(1);
      chk("f3_done", 32'(done), 32'd1);
      chk("f3_error", 32'(error), 32'd0);
      chk("f3_addr", 32'(prog_addr), 32'd0);
      $display("frame3 done=%0b addr=%0h data=%0h", done, prog_addr, prog_data);
      do_clear();

      // asynchronous reset mid-payload
      send(SYNC);
      send(8'h02);
      send(8'h08);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data", 32'(prog_data), 32'd0);
      chk("arst_addr", 32'(prog_addr), 32'd0);
      chk("arst_hold", 32'(cpu_hold), 32'd0);
      chk("arst_ready", 32'(byte_ready), 32'd1);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      send(8'h01);
      send(8'h48);
      cyc(2);
      chk("arst_nowrite_hold", 32'(cpu_hold), 32'd0);

      // longer back-to-back frame
      words = {};
      for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
      send_frame(1'b1);
      cyc(2);
      chk("f4_done", 32'(done), 32'd1);
      chk("f4_addr", 32'(prog_addr), 32'd4);
      chk("f4_data", 32'(prog_data), 32'(words[4]));
      chk("final_drain", 32'(sb.size()), 32'd0);
      do_clear();
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
